// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one cipher round per cycle, with the round
// keys supplied combinationally by an external key memory indexed by `round`.

module sbox (
  input  logic [7:0] din,
  output logic [7:0] sub_c
);

  // FIPS-197 forward S-box; entry 0 sits in the most significant byte.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub_c = SBOX_TBL[~din];

endmodule

module aes_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_RND = 4'd10;

  state_t          state_q, state_d;
  logic [3:0]      rnd, rnd_d;
  logic [127:0]    st, st_d;
  logic [0:15][7:0] st_b, sb_b, sr_b;
  logic [127:0]    sr, mc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign st_b = st;

  // SubBytes then ShiftRows: byte (r,c) takes the substituted byte from column c+r.
  for (genvar g = 0; g < 16; g++) begin : gen_sub
    sbox u_sbox (.din(st_b[g]), .sub_c(sb_b[g]));
  end

  for (genvar c = 0; c < 4; c++) begin : gen_sr_col
    for (genvar r = 0; r < 4; r++) begin : gen_sr_row
      assign sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
    end
  end

  assign sr = sr_b;

  for (genvar c = 0; c < 4; c++) begin : gen_mc
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd;
    st_d    = st;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          st_d    = plaintext ^ round_key;
          rnd_d   = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rnd == LAST_RND) begin
          st_d    = sr ^ round_key;
          rnd_d   = 4'd0;
          state_d = DONE;
        end else begin
          st_d  = mc ^ round_key;
          rnd_d = rnd + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rnd       <= 4'd0;
      st        <= 128'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd       <= rnd_d;
      st        <= st_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign round      = rnd;
  assign ciphertext = st;

endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES-128 encryption datapath and controller, placed directly downstream of the AES key memory. It accepts one 128-bit plaintext block over a valid/ready handshake and drives the round index to the key memory. Each cycle it consumes the returned round key and performs one cipher round. The ciphertext is presented on a valid/ready output handshake. The block reuses the existing `sbox` byte-substitution module and contains 16 instances of it.

## Interface
- No parameters. The cipher is fixed to AES-128 with 10 rounds.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `plaintext` is valid.
- `in_ready`  out  1  the engine can accept a block. High only in the IDLE state.
- `plaintext`  in  128  input block.
- `round`  out  4  round-key index to the key memory. Index 0 is the cipher key; index 10 is the last round key.
- `round_key`  in  128  key memory output for `round`. It is combinational and used in the same cycle.
- `out_valid`  out  1  `ciphertext` is valid. High only in the DONE state.
- `out_ready`  in  1  the consumer takes `ciphertext`.
- `ciphertext`  out  128  result block.
- `busy`  out  1  high in the RUN and DONE states.

## Operation
- **Byte order (FIPS-197):** byte 0 = bits [127:120]. The state is column-major: column c = bits [127-32c -: 32], and row r of column c is byte 4c+r.
- **Registers:**
  - FSM: IDLE, RUN, DONE.
  - 4-bit round counter `rnd`, driven directly onto `round`.
  - 128-bit state register `st`, driven directly onto `ciphertext`.
- **Reset values:** state = IDLE, `rnd` = 0, `st` = 0, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `ciphertext` = 0, `round` = 0.
- **IDLE:**
  - `round` = 0, so `round_key` is the cipher key.
  - When `in_valid` && `in_ready`: `st` <= `plaintext` ^ `round_key` (initial AddRoundKey), `rnd` <= 1, go to RUN.
  - Otherwise hold all registers.
- **RUN with `rnd` = 1..9:**
  - `st` <= MixColumns(ShiftRows(SubBytes(`st`))) ^ `round_key`.
  - `rnd` <= `rnd` + 1.
- **RUN with `rnd` = 10:**
  - `st` <= ShiftRows(SubBytes(`st`)) ^ `round_key`. MixColumns is skipped.
  - `rnd` <= 0, go to DONE.
- **SubBytes:** 16 parallel `sbox` instances, one per byte.
- **ShiftRows:** row r is rotated left by r columns.
- **MixColumns:** standard GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  - `xtime(b)` = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).
  - All arithmetic is byte-wide XOR; there are no carries.
- **DONE:**
  - `ciphertext` = `st`, held stable, with `out_valid` = 1 and `round` = 0.
  - When `out_ready` = 1: go to IDLE. `st` is not cleared.
- **Key memory input:** the key driven into the key memory must be held stable from the accept cycle through the last RUN cycle. The engine does not latch the key.

## Timing
- **Latency:** accept at rising edge E0. Rounds 1..10 execute on edges E1..E10. `out_valid` is high from just after E10.
- **Throughput:** with `out_ready` held at 1, the handshake completes on E11, IDLE is entered, and the next accept is no earlier than E12. That is one block per 12 cycles.
- **`round` sequence:** 0 (IDLE), then 1,2,…,10 during RUN, then 0 in DONE and IDLE. The combinational path `round` → key memory → `round_key` → `st` must close within one cycle.
- **Input while not IDLE:** `in_valid` in RUN or DONE is ignored (`in_ready` = 0). The source must hold `plaintext` until the handshake.
- **Output backpressure:** `out_ready` low in DONE holds the engine in DONE indefinitely, with `ciphertext` unchanged.
- **`out_ready` outside DONE:** has no effect.
- **Reset mid-operation:** `rst` high in any state forces all reset values on the next edge. No partial result is emitted, and `in_ready` = 1 in the following cycle.
- **Simultaneous `rst` and handshake:** `rst` wins.

## Test plan
- **Reset values:** apply reset → `in_ready` = 1, `out_valid` = 0, `busy` = 0, `round` = 0, `ciphertext` = 0.
- **FIPS-197 C.1:** key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → `ciphertext` 69c4e0d86a7b0430d8cdb78070b4c55a. `out_valid` is first seen 10 edges after the accept edge, and `round` steps 1..10 then returns to 0.
- **FIPS-197 App. B with backpressure:** key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, `out_ready` held low for 5 cycles → `ciphertext` 3925841d02dc09fbdc118597196a0b32, stable with `out_valid` = 1 for all 5 cycles. `in_valid` toggling during this period is not accepted.
- **Back-to-back blocks:** `in_valid` and `out_ready` held at 1 with the C.1 block followed by the App. B block → both correct results, accepts 12 cycles apart, no dropped or duplicated `out_valid`.
- **Reset mid-operation:** assert `rst` when `round` = 5 → next cycle IDLE with reset values. A following C.1 block still produces 69c4e0d86a7b0430d8cdb78070b4c55a.
